// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// Holds the controller state encoding and the pattern-length validity rule.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } state_e;

  localparam int MIN_LEN = 2;

  function automatic logic len_is_valid(input int len, input int max_len);
    return (len >= MIN_LEN) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Control, configuration and serial-stream signals of the sequence detector.
// The master side drives configuration and bits; the slave side is the detector.
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               seq_in;
  logic               seq_valid;
  logic               det_out;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, seq_in, seq_valid,
    input  cfg_ready, cfg_err, det_out, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, seq_in, seq_valid,
    output cfg_ready, cfg_err, det_out, match_count, busy, done
  );

endinterface

// File: rtl/seq_detect_ctrl_core.sv
// Shift history, fill counter and masked pattern compare for the detector.
// match is combinational on the post-shift view so the controller can register it.
module seq_match_core #(
  parameter  int MAX_LEN = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               match
);

  logic [MAX_LEN-1:0] history_q, history_d, history_sh, mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_sh;

  always_comb begin
    history_sh = {history_q[MAX_LEN-2:0], bit_in};
    fill_sh    = (fill_q < len) ? fill_q + LEN_W'(1) : fill_q;
    mask       = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    match = shift_en && (fill_sh >= len) && (((history_sh ^ pattern) & mask) == '0);
  end

  // A clear also wipes history; stale bits are never compared since fill restarts at zero.
  always_comb begin
    history_d = history_q;
    fill_d    = fill_q;
    if (clr) begin
      history_d = '0;
      fill_d    = '0;
    end else if (shift_en) begin
      history_d = history_sh;
      fill_d    = fill_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history_q <= '0;
      fill_q    <= '0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence detector controller: config handshake, arm/run/done FSM and match counter.
// All outputs are registered from the next-state view of the FSM.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] cfg_pattern_q, cfg_pattern_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
  logic               cfg_overlap_q, cfg_overlap_d;
  logic [CNT_W-1:0]   cfg_target_q, cfg_target_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d, count_inc;
  logic               det_out_q, det_out_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept, cfg_ok, shift_en, core_clr, core_match;

  assign accept    = bus.cfg_valid && cfg_ready_q;
  assign cfg_ok    = len_is_valid(int'(bus.cfg_len), MAX_LEN);
  assign shift_en  = (state_q == RUN) && bus.seq_valid && !bus.abort;
  assign count_inc = (match_count_q == '1) ? match_count_q : match_count_q + CNT_W'(1);

  seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (core_clr),
    .shift_en (shift_en),
    .bit_in   (bus.seq_in),
    .len      (cfg_len_q),
    .pattern  (cfg_pattern_q),
    .match    (core_match)
  );

  always_comb begin
    state_d       = state_q;
    cfg_pattern_d = cfg_pattern_q;
    cfg_len_d     = cfg_len_q;
    cfg_overlap_d = cfg_overlap_q;
    cfg_target_d  = cfg_target_q;
    match_count_d = match_count_q;
    det_out_d     = 1'b0;
    cfg_err_d     = 1'b0;
    core_clr      = 1'b0;
    case (state_q)
      IDLE, ARMED: begin
        if (accept) begin
          if (cfg_ok) begin
            cfg_pattern_d = bus.cfg_pattern;
            cfg_len_d     = bus.cfg_len;
            cfg_overlap_d = bus.cfg_overlap;
            cfg_target_d  = bus.cfg_target;
            state_d       = ARMED;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (state_q == ARMED && bus.start) begin
          state_d       = RUN;
          core_clr      = 1'b1;
          match_count_d = '0;
        end
      end
      RUN: begin
        // Abort also suppresses a match on the same edge, since shift_en is gated by it.
        if (bus.abort) begin
          state_d = ARMED;
        end else if (core_match) begin
          det_out_d     = 1'b1;
          match_count_d = count_inc;
          core_clr      = !cfg_overlap_q;
          if (cfg_target_q != '0 && count_inc == cfg_target_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_d = ARMED;
        end else if (bus.start) begin
          state_d       = RUN;
          core_clr      = 1'b1;
          match_count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    cfg_ready_d = (state_d == IDLE) || (state_d == ARMED);
    busy_d      = (state_d == RUN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cfg_pattern_q <= '0;
      cfg_len_q     <= '0;
      cfg_overlap_q <= 1'b0;
      cfg_target_q  <= '0;
      match_count_q <= '0;
      det_out_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      cfg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_pattern_q <= cfg_pattern_d;
      cfg_len_q     <= cfg_len_d;
      cfg_overlap_q <= cfg_overlap_d;
      cfg_target_q  <= cfg_target_d;
      match_count_q <= match_count_d;
      det_out_q     <= det_out_d;
      cfg_err_q     <= cfg_err_d;
      cfg_ready_q   <= cfg_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.det_out     = det_out_q;
  assign bus.match_count = match_count_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE} mode_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mode_t              mState;
  logic [MAX_LEN-1:0] mPat;
  int                 mLen;
  bit                 mOvl;
  int                 mTgt;
  int                 mCount;
  bit                 mDet;
  bit                 mErr;
  bit                 bitQ[$];

  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: a queue of bits received since the last (re)start or non-overlap match.
  task automatic modelEdge();
    mode_t prev;
    bit    accept;
    bit    hit;
    prev = mState;
    mDet = 1'b0;
    mErr = 1'b0;
    if (rst) begin
      mState = M_IDLE;
      mPat   = '0;
      mLen   = 0;
      mOvl   = 1'b0;
      mTgt   = 0;
      mCount = 0;
      bitQ.delete();
      return;
    end
    accept = bus.cfg_valid && (prev == M_IDLE || prev == M_ARMED);
    case (prev)
      M_IDLE, M_ARMED: begin
        if (accept) begin
          if (int'(bus.cfg_len) >= 2 && int'(bus.cfg_len) <= MAX_LEN) begin
            mPat   = bus.cfg_pattern;
            mLen   = int'(bus.cfg_len);
            mOvl   = bus.cfg_overlap;
            mTgt   = int'(bus.cfg_target);
            mState = M_ARMED;
          end else begin
            mErr = 1'b1;
          end
        end
        if (prev == M_ARMED && bus.start) begin
          mState = M_RUN;
          mCount = 0;
          bitQ.delete();
        end
      end
      M_RUN: begin
        if (bus.abort) begin
          mState = M_ARMED;
        end else if (bus.seq_valid) begin
          bitQ.push_back(bus.seq_in);
          while (bitQ.size() > MAX_LEN) void'(bitQ.pop_front());
          hit = (bitQ.size() >= mLen);
          for (int k = 0; k < mLen; k++) begin
            if (hit && bitQ[bitQ.size() - 1 - k] != mPat[k]) hit = 1'b0;
          end
          if (hit) begin
            mDet = 1'b1;
            if (mCount < (1 << CNT_W) - 1) mCount++;
            if (!mOvl) bitQ.delete();
            if (mTgt != 0 && mCount == mTgt) mState = M_DONE;
          end
        end
      end
      M_DONE: begin
        if (bus.abort) begin
          mState = M_ARMED;
        end else if (bus.start) begin
          mState = M_RUN;
          mCount = 0;
          bitQ.delete();
        end
      end
      default: mState = M_IDLE;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/cfg_ready"}, 32'(bus.cfg_ready), 32'(mState == M_IDLE || mState == M_ARMED));
    checkOutput({tag, "/cfg_err"}, 32'(bus.cfg_err), 32'(mErr));
    checkOutput({tag, "/det_out"}, 32'(bus.det_out), 32'(mDet));
    checkOutput({tag, "/match_count"}, 32'(bus.match_count), 32'(mCount));
    checkOutput({tag, "/busy"}, 32'(bus.busy), 32'(mState == M_RUN));
    checkOutput({tag, "/done"}, 32'(bus.done), 32'(mState == M_DONE));
  endtask

  task automatic applyStimulus(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic clearInputs();
    rst           = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.seq_in    = 1'b0;
    bus.seq_valid = 1'b0;
  endtask

  task automatic sendCfg(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl, input int tgt, input string tag);
    clearInputs();
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_overlap = ovl;
    bus.cfg_target  = CNT_W'(tgt);
    applyStimulus(tag);
    clearInputs();
  endtask

  task automatic doStart(input string tag);
    clearInputs();
    bus.start = 1'b1;
    applyStimulus(tag);
    clearInputs();
  endtask

  task automatic sendBit(input bit b, input bit v, input bit ab, input string tag);
    clearInputs();
    bus.seq_in    = b;
    bus.seq_valid = v;
    bus.abort     = ab;
    applyStimulus(tag);
    clearInputs();
  endtask

  task automatic doReset(input string tag);
    clearInputs();
    rst = 1'b1;
    applyStimulus(tag);
    clearInputs();
  endtask

  // Bits are sent oldest first, i.e. from bit n-1 down to bit 0 of the vector.
  task automatic streamBits(input logic [15:0] bits, input int n, input bit gaps, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      sendBit(bits[i], 1'b1, 1'b0, tag);
      if (gaps) sendBit(1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    clearInputs();
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.cfg_target  = '0;
    mState = M_IDLE;
    mPat   = '0;
    mLen   = 0;
    mOvl   = 1'b0;
    mTgt   = 0;
    mCount = 0;

    doReset("reset");
    checkOutput("reset_ready", 32'(bus.cfg_ready), 32'd1);
    checkOutput("reset_count", 32'(bus.match_count), 32'd0);

    sendCfg(8'h00, 0, 1'b0, 0, "cfg_len0");
    checkOutput("err_len0", 32'(bus.cfg_err), 32'd1);
    sendCfg(8'h00, MAX_LEN + 1, 1'b0, 0, "cfg_len9");
    checkOutput("err_len9", 32'(bus.cfg_err), 32'd1);
    checkOutput("err_ready", 32'(bus.cfg_ready), 32'd1);
    doStart("idle_start");
    checkOutput("idle_start_busy", 32'(bus.busy), 32'd0);

    sendCfg(8'b1011, 4, 1'b1, 0, "cfg_ovl");
    doStart("start_ovl");
    streamBits(16'b1011011, 7, 1'b0, "ovl");
    checkOutput("ovl_count", 32'(bus.match_count), 32'd2);
    checkOutput("ovl_busy", 32'(bus.busy), 32'd1);

    sendBit(1'b0, 1'b0, 1'b1, "abort1");
    sendCfg(8'b1011, 4, 1'b0, 0, "cfg_novl");
    doStart("start_novl");
    streamBits(16'b1011011, 7, 1'b0, "novl");
    checkOutput("novl_count", 32'(bus.match_count), 32'd1);

    sendBit(1'b0, 1'b0, 1'b1, "abort2");
    sendCfg(8'b110, 3, 1'b0, 2, "cfg_tgt");
    doStart("start_tgt");
    streamBits(16'b110110, 6, 1'b1, "tgt");
    checkOutput("tgt_done", 32'(bus.done), 32'd1);
    checkOutput("tgt_busy", 32'(bus.busy), 32'd0);
    checkOutput("tgt_ready", 32'(bus.cfg_ready), 32'd0);
    checkOutput("tgt_count", 32'(bus.match_count), 32'd2);

    sendBit(1'b0, 1'b0, 1'b1, "done_abort");
    doStart("start_abm");
    streamBits(16'b11011, 5, 1'b0, "abm");
    sendBit(1'b0, 1'b1, 1'b1, "abm_final");
    checkOutput("abm_det", 32'(bus.det_out), 32'd0);
    checkOutput("abm_count", 32'(bus.match_count), 32'd1);
    checkOutput("abm_ready", 32'(bus.cfg_ready), 32'd1);
    doStart("restart_abm");
    checkOutput("restart_count", 32'(bus.match_count), 32'd0);

    sendBit(1'b0, 1'b0, 1'b1, "abort3");
    sendCfg(8'b1011, 4, 1'b1, 0, "cfg_rst");
    doStart("start_rst");
    streamBits(16'b1011011, 7, 1'b0, "rstrun");
    doReset("midrun_reset");
    checkOutput("rst_count", 32'(bus.match_count), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_ready", 32'(bus.cfg_ready), 32'd1);
    doStart("rst_start");
    checkOutput("rst_start_busy", 32'(bus.busy), 32'd0);

    sendCfg(8'b11, 2, 1'b1, 0, "cfg_sat");
    doStart("start_sat");
    for (int i = 0; i < 300; i++) sendBit(1'b1, 1'b1, 1'b0, "sat");
    checkOutput("sat_count", 32'(bus.match_count), 32'd255);

    for (int i = 0; i < 2000; i++) begin
      clearInputs();
      rst             = ($urandom_range(0, 499) == 0);
      bus.cfg_valid   = ($urandom_range(0, 7) == 0);
      bus.cfg_pattern = MAX_LEN'($urandom);
      bus.cfg_len     = LEN_W'($urandom_range(0, MAX_LEN + 1));
      bus.cfg_overlap = 1'($urandom_range(0, 1));
      bus.cfg_target  = CNT_W'($urandom_range(0, 3));
      bus.start       = ($urandom_range(0, 15) == 0);
      bus.abort       = ($urandom_range(0, 31) == 0);
      bus.seq_in      = 1'($urandom_range(0, 1));
      bus.seq_valid   = ($urandom_range(0, 3) != 0);
      applyStimulus("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
